mem_bus_master: RTL

- MEM-stage consumer of the EX/MEM pipeline register outputs: address, store data, size/extension controls and the write strobe.
- Turns each load/store into a request on a req/ack data bus and stalls the pipeline until the access completes.
- Generates byte enables and store-lane replication; aligns, sign-extends or zero-extends load data returned to the writeback path.

---
 rtl/mem_pkg.sv | 18 +
 rtl/mem_lane_ext.sv | 47 ++++
 rtl/mem_bus_master.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage bus master: access sizes, load extension modes, FSM states.
package mem_pkg;
    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    localparam logic [2:0] EXT_NONE = 3'b000;
    localparam logic [2:0] EXT_ZB   = 3'b001;
    localparam logic [2:0] EXT_SB   = 3'b010;
    localparam logic [2:0] EXT_ZH   = 3'b011;
    localparam logic [2:0] EXT_SH   = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DONE
    } state_t;
endpackage

// File: rtl/mem_lane_ext.sv
// Byte-lane logic: byte enables and store replication for the outgoing access,
// lane selection plus zero/sign extension for the returned read word.
module mem_lane_ext
    import mem_pkg::*;
(
    input  logic [1:0]  st_addr_i,
    input  logic [1:0]  size_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  ld_addr_i,
    input  logic [2:0]  ext_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        case (size_i)
            SZ_HALF: begin
                be_o    = st_addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
            end
            SZ_BYTE: begin
                be_o    = 4'b0001 << st_addr_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        byte_v  = rdata_i[{ld_addr_i, 3'b000} +: 8];
        half_v  = ld_addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        rdata_o = rdata_i;
        case (ext_i)
            EXT_ZB:  rdata_o = {24'b0, byte_v};
            EXT_SB:  rdata_o = {{24{byte_v[7]}}, byte_v};
            EXT_ZH:  rdata_o = {16'b0, half_v};
            EXT_SH:  rdata_o = {{16{half_v[15]}}, half_v};
            default: ;
        endcase
    end
endmodule

// File: rtl/mem_bus_master.sv
// MEM-stage load/store master on a req/ack bus; stalls the pipeline until the access retires.
// Build option MEM_ALIGN_CHECK_EN: trap misaligned half/word accesses instead of issuing them.
module mem_bus_master
    import mem_pkg::*;
#(
    parameter int WAIT_LIMIT = 255,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read_M,
    input  logic              MemWrite_M,
    input  logic [31:0]       addr_M,
    input  logic [31:0]       wdata_M,
    input  logic [1:0]        size_M,
    input  logic [2:0]        ext_M,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata,
    output logic              stall_o,
    output logic [31:0]       rdata_M,
    output logic              bus_err,
    output logic              align_err
);
    localparam logic [15:0] CNT_LAST = 16'(WAIT_LIMIT - 1);

    state_t            state_q;
    logic [15:0]       cnt_q;
    logic              req_q, we_q, err_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q, rdata_q;
    logic [1:0]        addr_lo_q;
    logic [2:0]        ext_q;

    logic              access;
    logic [3:0]        be_d;
    logic [31:0]       wdata_d, ld_ext;

    assign access = mem_read_M | MemWrite_M;

    mem_lane_ext u_lane (
        .st_addr_i (addr_M[1:0]),
        .size_i    (size_M),
        .wdata_i   (wdata_M),
        .ld_addr_i (addr_lo_q),
        .ext_i     (ext_q),
        .rdata_i   (bus_rdata),
        .be_o      (be_d),
        .wdata_o   (wdata_d),
        .rdata_o   (ld_ext)
    );

`ifdef MEM_ALIGN_CHECK_EN
    logic align_q, misalign;
    always_comb begin
        case (size_M)
            SZ_HALF: misalign = addr_M[0];
            SZ_BYTE: misalign = 1'b0;
            default: misalign = (addr_M[1:0] != 2'b00);
        endcase
    end
    assign align_err = align_q;
`else
    assign align_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            be_q      <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            addr_lo_q <= '0;
            ext_q     <= '0;
`ifdef MEM_ALIGN_CHECK_EN
            align_q   <= 1'b0;
`endif
        end else begin
            err_q <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            align_q <= 1'b0;
`endif
            case (state_q)
                ST_IDLE: if (access) begin
`ifdef MEM_ALIGN_CHECK_EN
                    if (misalign) begin
                        align_q <= 1'b1;
                        rdata_q <= '0;
                        state_q <= ST_DONE;
                    end else
`endif
                    begin
                        req_q     <= 1'b1;
                        we_q      <= MemWrite_M;
                        addr_q    <= {addr_M[ADDR_W-1:2], 2'b00};
                        be_q      <= be_d;
                        wdata_q   <= wdata_d;
                        addr_lo_q <= addr_M[1:0];
                        ext_q     <= ext_M;
                        state_q   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus_ack) begin
                        req_q   <= 1'b0;
                        cnt_q   <= '0;
                        if (!we_q) rdata_q <= ld_ext;
                        state_q <= ST_DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        req_q   <= 1'b0;
                        cnt_q   <= '0;
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // REQ stalls even on the ack cycle: rdata_M only becomes valid in DONE, where the pipeline advances.
    assign stall_o   = ~reset & (((state_q == ST_IDLE) & access) | (state_q == ST_REQ));
    assign bus_req   = req_q;
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_be    = be_q;
    assign bus_wdata = wdata_q;
    assign rdata_M   = rdata_q;
    assign bus_err   = err_q;
endmodule
